// File: rtl/lsu_pkg.sv
// Shared definitions for the data RAM load/store unit.
// Op encodings, FSM states and default widths.
package lsu_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_RD_WAIT,
    S_FILL,
    S_RESP
  } state_t;

endpackage

// File: rtl/data_ram_lsu.sv
// Load/store sequencer in front of a 16x8 registered-read RAM.
// Handles LOAD, STORE, FILL and flags reserved ops.
module data_ram_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [ADDR_W-1:0] CNT_LAST = '1;

  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_valid;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  state_t            w_state;
  logic [ADDR_W-1:0] w_cnt;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_valid;
  logic [DATA_W-1:0] w_rdata;
  logic              w_err;

  // Ready and busy decode straight from state.
  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);

  assign ram_we    = r_we;
  assign ram_addr  = r_addr;
  assign ram_wdata = r_wdata;
  assign rsp_valid = r_valid;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  // State, fill counter and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_valid <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_we    <= w_we;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
      r_valid <= w_valid;
      r_rdata <= w_rdata;
      r_err   <= w_err;
    end
  end

  // Next state plus the output values for the next cycle.
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_we    = 1'b0;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    w_valid = 1'b0;
    w_rdata = r_rdata;
    w_err   = r_err;
    unique case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          unique case (1'b1)
            (req_op == OP_LOAD): begin
              w_state = S_READ;
              w_addr  = req_addr;
            end
            (req_op == OP_STORE): begin
              w_state = S_WRITE;
              w_we    = 1'b1;
              w_addr  = req_addr;
              w_wdata = req_wdata;
            end
            (req_op == OP_FILL): begin
              w_state = S_FILL;
              w_cnt   = '0;
              w_we    = 1'b1;
              w_addr  = '0;
              w_wdata = req_wdata;
            end
            default: begin
              w_state = S_RESP;
              w_valid = 1'b1;
              w_rdata = '0;
              w_err   = 1'b1;
            end
          endcase
        end
      end
      S_WRITE: begin
        w_state = S_RESP;
        w_valid = 1'b1;
        w_rdata = '0;
        w_err   = 1'b0;
      end
      S_READ: begin
        w_state = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        w_state = S_RESP;
        w_valid = 1'b1;
        w_rdata = ram_rdata;
        w_err   = 1'b0;
      end
      S_FILL: begin
        w_cnt = r_cnt + 1'b1;
        if (r_cnt == CNT_LAST) begin
          w_state = S_RESP;
          w_valid = 1'b1;
          w_rdata = '0;
          w_err   = 1'b0;
        end else begin
          w_we   = 1'b1;
          w_addr = r_cnt + 1'b1;
        end
      end
      S_RESP: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_data_ram_lsu.sv
// Scoreboard bench for data_ram_lsu with a 16x8
// registered-read RAM model attached.
module tb_data_ram_lsu;
  import lsu_pkg::*;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = 2'b00;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          busy;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            due;
  } exp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            edge_n;
  } wr_t;

  exp_t sb[$];
  wr_t  wlog[$];
  int   acc_q[$];
  exp_t e_pop;

  logic [DW-1:0] mem [16];
  logic [DW-1:0] mdl [16];

  int n_pass = 0;
  int n_chk  = 0;
  int ecnt   = 0;
  int rsp_cnt = 0;

  data_ram_lsu #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  // Registered-read RAM seen by the unit.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  // Monitor: write log, response checks, accept tracking.
  always @(negedge clk) begin
    if (ram_we)
      wlog.push_back('{ram_addr, ram_wdata, ecnt});
    if (rsp_valid) begin
      rsp_cnt++;
      if (sb.size() == 0) begin
        chk("spurious_rsp", 1, 0);
      end else begin
        e_pop = sb.pop_front();
        chk("rsp_latency", ecnt, e_pop.due);
        chk("rsp_rdata", {24'h0, rsp_rdata},
            {24'h0, e_pop.rdata});
        chk("rsp_err", {31'h0, rsp_err},
            {31'h0, e_pop.err});
      end
    end
    if (rst_n && req_valid && req_ready) begin
      acc_q.push_back(ecnt + 1);
      case (req_op)
        OP_LOAD:
          sb.push_back('{mdl[req_addr], 1'b0, ecnt + 3});
        OP_STORE: begin
          mdl[req_addr] = req_wdata;
          sb.push_back('{8'h00, 1'b0, ecnt + 2});
        end
        OP_FILL: begin
          for (int i = 0; i < 16; i++) mdl[i] = req_wdata;
          sb.push_back('{8'h00, 1'b0, ecnt + 17});
        end
        default:
          sb.push_back('{8'h00, 1'b1, ecnt + 1});
      endcase
    end
  end

  task automatic do_req(input logic [1:0] op,
                        input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    int n;
    n = 0;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = a;
    req_wdata = d;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op    = 2'($urandom);
    req_addr  = AW'($urandom);
    req_wdata = DW'($urandom);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("rsp_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    int rc;
    for (int i = 0; i < 16; i++) begin
      mem[i] = '0;
      mdl[i] = '0;
    end

    // Reset with random request activity.
    wlog.delete();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      req_valid = 1'($urandom);
      req_op    = 2'($urandom);
      req_addr  = AW'($urandom);
      req_wdata = DW'($urandom);
      @(negedge clk);
      chk("rst_outs",
          {req_ready, busy, rsp_valid, rsp_err, ram_we,
           ram_addr, ram_wdata, rsp_rdata},
          {5'b10000, 20'h0});
    end
    chk("rst_no_we", wlog.size(), 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_rst", {busy, req_ready}, 2'b01);

    // STORE then LOAD at address 1.
    wlog.delete();
    do_req(OP_STORE, 4'd1, 8'hFF);
    wait_done();
    chk("st_we_cnt", wlog.size(), 1);
    if (wlog.size() > 0) begin
      chk("st_addr", wlog[0].addr, 1);
      chk("st_data", wlog[0].data, 8'hFF);
    end
    do_req(OP_LOAD, 4'd1, 8'h00);
    wait_done();
    chk("ld_no_we", wlog.size(), 1);

    // FILL 0xAA, then read both ends.
    wlog.delete();
    do_req(OP_FILL, 4'd9, 8'hAA);
    wait_done();
    chk("fill_we_cnt", wlog.size(), 16);
    if (wlog.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        chk("fill_addr", wlog[i].addr, i);
        chk("fill_data", wlog[i].data, 8'hAA);
        chk("fill_consec", wlog[i].edge_n - wlog[0].edge_n, i);
      end
    end
    do_req(OP_LOAD, 4'd15, 8'h00);
    wait_done();
    do_req(OP_LOAD, 4'd0, 8'h00);
    wait_done();

    // Back-to-back with req_valid held high.
    acc_q.delete();
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_op    = OP_STORE;
    req_addr  = 4'd3;
    req_wdata = 8'hF0;
    n = 0;
    while (acc_q.size() == 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    req_op   = OP_LOAD;
    req_addr = 4'd3;
    @(negedge clk);
    chk("b2b_busy_wr", {busy, req_ready}, 2'b10);
    @(negedge clk);
    chk("b2b_busy_rsp", {busy, req_ready}, 2'b10);
    @(posedge clk); #1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("b2b_acc_n", acc_q.size(), 2);
    chk("b2b_gap",
        (acc_q.size() == 2) ? acc_q[1] - acc_q[0] : -1, 3);
    wait_done();

    // Reserved op.
    wlog.delete();
    do_req(OP_RSVD, 4'd5, 8'h77);
    wait_done();
    chk("rsvd_no_we", wlog.size(), 0);

    // FILL 0x00, then abort FILL 0x55 at address 7.
    do_req(OP_FILL, 4'd0, 8'h00);
    wait_done();
    wlog.delete();
    do_req(OP_FILL, 4'd0, 8'h55);
    n = 0;
    while (!(ram_we && ram_addr == 4'd7) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach7", {ram_we, ram_addr}, {1'b1, 4'd7});
    rst_n = 1'b0;
    #1;
    chk("abort_we", ram_we, 0);
    chk("abort_state", {busy, req_ready, rsp_valid}, 3'b010);
    sb.delete();
    for (int i = 7; i < 16; i++) mdl[i] = '0;
    rc = rsp_cnt;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) @(negedge clk);
    chk("abort_no_rsp", rsp_cnt - rc, 0);
    do_req(OP_LOAD, 4'd6, 8'h00);
    wait_done();
    do_req(OP_LOAD, 4'd7, 8'h00);
    wait_done();
    do_req(OP_LOAD, 4'd8, 8'h00);
    wait_done();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
